// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-stream decoder: FSM state encoding
// and the default decode window size.
package sc_pkg;

  localparam int WIN_LOG2_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } sc_state_e;

endpackage

// File: rtl/sc_ones_counter.sv
// Window and ones counters for one decode window.
// `count` is the ones total after the current cycle's update. When
// `window_full` is high, `count` therefore already includes the bit that
// completes the window.
module sc_ones_counter
  import sc_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic              bit_in,
  output logic              window_full,
  output logic [WIN_LOG2:0] count
);

  // Last window index before wrap: 2^WIN_LOG2 - 1.
  localparam logic [WIN_LOG2:0] WIN_LAST = {1'b0, {WIN_LOG2{1'b1}}};

  logic [WIN_LOG2:0] win_q, win_d;
  logic [WIN_LOG2:0] ones_q, ones_d;

  // Next-count logic: clear wins over enable; only enabled cycles count.
  always_comb begin
    win_d  = win_q;
    ones_d = ones_q;
    if (clear) begin
      win_d  = '0;
      ones_d = '0;
    end else if (enable) begin
      win_d  = win_q + 1'b1;
      ones_d = ones_q + {{WIN_LOG2{1'b0}}, bit_in};
    end
    window_full = enable && !clear && (win_q == WIN_LAST);
    count       = ones_d;
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q  <= '0;
      ones_q <= '0;
    end else begin
      win_q  <= win_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic bitstream decoder. It counts the ones in a window of
// 2^WIN_LOG2 qualified bits and publishes the total on `result`.
// Optional macro SC_DECODER_BIPOLAR_EN selects bipolar output encoding:
// result = 2*ones - 2^WIN_LOG2 as two's complement.
// The default encoding is the unsigned ones count.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                busy,
  output logic                done,
  output logic [WIN_LOG2+1:0] result
);

  sc_state_e           state_q, state_d;
  logic [WIN_LOG2+1:0] result_q, result_d;
  logic                cnt_clear;
  logic                cnt_enable;
  logic                window_full;
  logic [WIN_LOG2:0]   ones_count;

  // Map a completed ones count onto the output encoding.
  function automatic logic [WIN_LOG2+1:0] to_result(input logic [WIN_LOG2:0] ones);
`ifdef SC_DECODER_BIPOLAR_EN
    logic [WIN_LOG2+1:0] twice;
    logic [WIN_LOG2+1:0] offset;
    twice  = {ones, 1'b0};
    offset = {2'b01, {WIN_LOG2{1'b0}}};
    return twice - offset;
`else
    return {1'b0, ones};
`endif
  endfunction

  sc_ones_counter #(
    .WIN_LOG2(WIN_LOG2)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cnt_clear),
    .enable     (cnt_enable),
    .bit_in     (bit_in),
    .window_full(window_full),
    .count      (ones_count)
  );

  // Next-state and counter control. A start arriving mid-window is ignored.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = COUNT;
        end
      end
      COUNT: begin
        cnt_enable = bit_valid;
        if (window_full) begin
          result_d = to_result(ones_count);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = COUNT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == COUNT);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder with WIN_LOG2 = 8.
module tb_sc_stream_decoder;

  localparam int W   = 8;
  localparam int WIN = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic         busy;
  logic         done;
  logic [W+1:0] result;

  int           tests  = 0;
  int           failed = 0;
  logic [W+1:0] prev_result;

  sc_stream_decoder #(.WIN_LOG2(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected decoded value of a window holding `ones` ones.
  function automatic logic [W+1:0] expected_of(input int ones);
`ifdef SC_DECODER_BIPOLAR_EN
    return (W+2)'(2 * ones - WIN);
`else
    return (W+2)'(ones);
`endif
  endfunction

  // Bit source: 0 all ones, 1 alternating 1/0, 2 all zeros, 3 random.
  function automatic bit pattern_bit(input int pat, input int idx);
    case (pat)
      0:       return 1'b1;
      1:       return (idx % 2) == 0;
      2:       return 1'b0;
      default: return 1'($urandom_range(1, 0));
    endcase
  endfunction

  // One decode window. gap>0 drops bit_valid every gap-th cycle; gap<0 drops
  // it at random. restart_at>0 pulses start with that qualified bit.
  task automatic run_window(input string name, input int pat, input int gap,
                            input int restart_at, input bit send_start,
                            input bit start_at_done);
    int           q;
    int           ones;
    int           cyc;
    bit           b;
    bit           hole;
    logic [W+1:0] exp;
    q    = 0;
    ones = 0;
    cyc  = 0;
    if (send_start) begin
      start     = 1'b1;
      bit_valid = 1'b0;
      tick();
      start = 1'b0;
      chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
    end
    while (q < WIN) begin
      if (gap > 0) hole = (cyc % gap) == (gap - 1);
      else if (gap < 0) hole = ($urandom_range(3, 0) == 0);
      else hole = 1'b0;
      if (hole) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(1, 0));
      end else begin
        b         = pattern_bit(pat, q);
        bit_valid = 1'b1;
        bit_in    = b;
        ones     += int'(b);
        q++;
      end
      start = (restart_at > 0) && !hole && (q == restart_at);
      tick();
      cyc++;
      start = 1'b0;
      if (q < WIN) begin
        if (busy !== 1'b1 || done !== 1'b0 || result !== prev_result) begin
          chk({name, "_busy_mid"}, 32'(busy), 32'd1);
          chk({name, "_done_mid"}, 32'(done), 32'd0);
          chk({name, "_result_hold"}, 32'(result), 32'(prev_result));
        end
      end
    end
    exp = expected_of(ones);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({name, "_result"}, 32'(result), 32'(exp));
    prev_result = exp;
    start     = start_at_done;
    bit_valid = 1'b0;
    tick();
    start = 1'b0;
    chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({name, "_busy_after_done"}, 32'(busy), 32'(start_at_done));
    chk({name, "_result_after_done"}, 32'(result), 32'(exp));
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b1;
    bit_in      = 1'b0;
    bit_valid   = 1'b1;
    prev_result = '0;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    rst_n     = 1'b1;
    start     = 1'b0;
    bit_valid = 1'b0;
    tick();
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    run_window("all_ones",  0, 0, 0,   1'b1, 1'b0);
    run_window("alternate", 1, 0, 0,   1'b1, 1'b0);
    run_window("all_zeros", 2, 0, 0,   1'b1, 1'b0);
    run_window("gap3_ones", 0, 3, 0,   1'b1, 1'b0);
    run_window("restart",   3, 0, 100, 1'b1, 1'b0);
    run_window("b2b_first", 3, 0, 0,   1'b1, 1'b1);
    run_window("b2b_next",  1, 0, 0,   1'b0, 1'b0);
    run_window("rand_gaps", 3, -1, 0,  1'b1, 1'b0);

    // Reset in the middle of a window: partial window is discarded.
    start     = 1'b1;
    bit_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 150; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
    end
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_result", 32'(result), 32'd0);
    rst_n       = 1'b1;
    start       = 1'b0;
    bit_valid   = 1'b1;
    prev_result = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) begin
        chk("post_reset_done", 32'(done), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);
      end
    end
    chk("post_reset_idle", 32'(busy), 32'd0);
    run_window("after_reset", 3, 0, 0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sc_stream_decoder.md
SC_STREAM_DECODER -- requirements
Module: sc_stream_decoder

Interface
REQ-001 SHALL have parameter: WIN_LOG2, default 8, log2 of the decode window length in stream bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: start  input  1  single-cycle request to begin a decode window.
REQ-005 SHALL have port: bit_in  input  1  stochastic bitstream sample.
REQ-006 SHALL have port: bit_valid  input  1  bit_in qualifier; only qualified bits are counted.
REQ-007 SHALL have port: busy  output  1  high while a window is being accumulated.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when result is updated.
REQ-009 SHALL have port: result  output  WIN_LOG2+2  decoded binary value, held between updates.

Function
REQ-010 SHALL implement FSM states IDLE, COUNT, DONE; encoding is free.
REQ-011 IDLE: start=1 SHALL move to COUNT next cycle, clearing the window and ones counters; otherwise stay IDLE.
REQ-012 COUNT: each cycle with bit_valid=1 SHALL increment the window counter and add bit_in to the ones counter; bit_valid=0 cycles SHALL change neither.
REQ-013 COUNT: the qualified bit that brings the window count to 2^WIN_LOG2 SHALL be included, the final value SHALL be written to result on that edge, and the FSM SHALL move to DONE.
REQ-014 DONE: done SHALL be 1 for exactly this one cycle; next state is COUNT if start=1 (back-to-back, counters cleared), else IDLE.
REQ-015 busy SHALL be 1 exactly when the state is COUNT.
REQ-016 start while in COUNT SHALL be ignored; the window is not restarted.
REQ-017 Latency: done SHALL assert the cycle after the 2^WIN_LOG2-th qualified bit is sampled.
REQ-018 Ones counter SHALL be WIN_LOG2+1 bits so an all-ones window (2^WIN_LOG2) does not wrap.
REQ-019 result SHALL change only on the edge that enters DONE.
REQ-020 result SHALL otherwise hold its value through IDLE and through subsequent windows until the next completion.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, and both counters to 0.
REQ-022 Reset asserted mid-COUNT SHALL discard the partial window with no done pulse; start SHALL be ignored while rst_n=0.

Configuration
REQ-023 SHALL support macro SC_DECODER_BIPOLAR_EN.
REQ-024 With SC_DECODER_BIPOLAR_EN defined, result SHALL be the two's-complement value 2*ones - 2^WIN_LOG2 (range -2^WIN_LOG2..+2^WIN_LOG2).
REQ-025 Without the macro, result SHALL be the unsigned ones count, zero-extended to WIN_LOG2+2 bits.

Structure
REQ-026 The FSM state enum and the WIN_LOG2 default constant SHALL reside in shared package sc_pkg.
REQ-027 The window and ones counters SHALL be one sub-module, sc_ones_counter (clear, enable, bit inputs; window_full and count outputs), instantiated once.

Verification (WIN_LOG2=8)
REQ-028 start, then 256 cycles of bit_valid=1, bit_in=1 -> done on the cycle after the 256th bit; result=256 unipolar, +256 bipolar.
REQ-029 start, then 256 qualified bits of alternating 1/0 -> result=128 unipolar, 0 bipolar; all-zeros window -> 0 unipolar, -256 bipolar.
REQ-030 start, then 256 qualified ones with bit_valid=0 on every third cycle -> done only after the 256th qualified bit, result=256; busy=1 throughout.
REQ-031 start re-pulsed at qualified bit 100 of a window -> ignored; done after bit 256 counted from the original start.
REQ-032 rst_n=0 for one cycle at qualified bit 150 -> IDLE, result=0, no done; a new start yields a full-length window.
REQ-033 start held high through DONE -> new window begins with no IDLE cycle; previous result holds until the second done.
